// File: rtl/mux_marshalling.sv
// mux_marshalling: serial-to-parallel marshaller built as a steered mux
// rather than a shift chain. A bit-position counter selects which slot of
// a staging register receives each sampled serial bit; when the last slot
// is filled the whole word, including that completing bit, is copied to
// byte_out on the same edge.
//
// Parameters:
//   DATA_W    - assembled word width (2..64)
//   MSB_FIRST - 0: first received bit lands in bit 0; 1: in bit DATA_W-1
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   serial_in  - serial data, one bit sampled per edge while rst=0
//   byte_out   - last fully assembled word, held between completions
//   byte_valid - (only with MUX_MARSHALLING_VALID_EN defined) one-cycle
//                pulse in the cycle byte_out has just been updated
//
// Optional feature macro: MUX_MARSHALLING_VALID_EN
module mux_marshalling #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  output logic [DATA_W-1:0] byte_out
`ifdef MUX_MARSHALLING_VALID_EN
  ,
  output logic              byte_valid
`endif
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] stage_q, stage_d;
  logic [DATA_W-1:0] byte_out_q, byte_out_d;
  logic [CNT_W-1:0]  slot;
  logic              last_bit;

  // Slot steering and word completion
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    stage_d    = stage_q;
    byte_out_d = byte_out_q;
    slot       = MSB_FIRST ? (LAST_CNT - bit_cnt_q) : bit_cnt_q;
    last_bit   = (bit_cnt_q == LAST_CNT);

    stage_d[slot] = serial_in;
    if (last_bit) begin
      // stage_d already carries the completing bit in its final slot
      byte_out_d = stage_d;
      bit_cnt_d  = '0;
    end else begin
      bit_cnt_d  = bit_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q  <= '0;
      stage_q    <= '0;
      byte_out_q <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      stage_q    <= stage_d;
      byte_out_q <= byte_out_d;
    end
  end

  assign byte_out = byte_out_q;

`ifdef MUX_MARSHALLING_VALID_EN
  logic byte_valid_q, byte_valid_d;

  // Pulse accompanies each byte_out update
  always_comb begin
    byte_valid_d = last_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_valid_q <= 1'b0;
    end else begin
      byte_valid_q <= byte_valid_d;
    end
  end

  assign byte_valid = byte_valid_q;
`endif

endmodule

// File: tb/tb_mux_marshalling.sv
// Testbench for mux_marshalling: drives one LSB-first and one MSB-first
// instance from the same stimulus and compares both against a bit-queue
// reference model after every edge.
module tb_mux_marshalling;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic [7:0] out_lsb;
  logic [7:0] out_msb;
`ifdef MUX_MARSHALLING_VALID_EN
  logic       valid_lsb;
  logic       valid_msb;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model state
  bit         bits_q[$];
  logic [7:0] exp_lsb = '0;
  logic [7:0] exp_msb = '0;
  logic       exp_valid = 1'b0;
  int unsigned valid_pulses = 0;

  always #5 clk = ~clk;

  mux_marshalling #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .byte_out  (out_lsb)
`ifdef MUX_MARSHALLING_VALID_EN
    ,
    .byte_valid(valid_lsb)
`endif
  );

  mux_marshalling #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .byte_out  (out_msb)
`ifdef MUX_MARSHALLING_VALID_EN
    ,
    .byte_valid(valid_msb)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: collect sampled bits, every 8 since reset form one word
  task automatic model_edge(input logic r, input logic b);
    exp_valid = 1'b0;
    if (r) begin
      bits_q.delete();
      exp_lsb = '0;
      exp_msb = '0;
    end else begin
      bits_q.push_back(b);
      if (bits_q.size() == 8) begin
        exp_lsb = '0;
        exp_msb = '0;
        for (int i = 0; i < 8; i++) begin
          exp_lsb = exp_lsb | (8'(bits_q[i]) << i);
          exp_msb = exp_msb | (8'(bits_q[i]) << (7 - i));
        end
        bits_q.delete();
        exp_valid = 1'b1;
      end
    end
  endtask

  // Apply one edge of stimulus, then compare both instances
  task automatic step(input logic r, input logic b);
    rst       = r;
    serial_in = b;
    @(posedge clk);
    #1;
    model_edge(r, b);
    check("lsb_byte_out", 64'(out_lsb), 64'(exp_lsb));
    check("msb_byte_out", 64'(out_msb), 64'(exp_msb));
`ifdef MUX_MARSHALLING_VALID_EN
    check("lsb_byte_valid", 64'(valid_lsb), 64'(exp_valid));
    check("msb_byte_valid", 64'(valid_msb), 64'(exp_valid));
    if (valid_lsb) valid_pulses++;
`endif
  endtask

  logic [31:0] word32;
  logic [7:0]  msb_pat;
  logic [7:0]  w5a;

  initial begin
    rst       = 1'b1;
    serial_in = 1'bx;

    // Reset with X on the serial input
    step(1'b1, 1'bx);
    step(1'b1, 1'bx);
    check("reset_byte_out", 64'(out_lsb), 64'h00);

    // LSB-first 32-bit stream
    word32 = 32'hABCD1234;
    valid_pulses = 0;
    for (int i = 0; i < 32; i++) begin
      step(1'b0, word32[i]);
      if (i == 7)  check("stream_byte0", 64'(out_lsb), 64'h34);
      if (i == 15) check("stream_byte1", 64'(out_lsb), 64'h12);
      if (i == 23) check("stream_byte2", 64'(out_lsb), 64'hCD);
      if (i == 31) check("stream_byte3", 64'(out_lsb), 64'hAB);
      if (i == 14) check("stream_hold1", 64'(out_lsb), 64'h34);
    end
`ifdef MUX_MARSHALLING_VALID_EN
    check("valid_pulse_count", 64'(valid_pulses), 64'd4);
`endif

    // Continuous run of ones
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1);
      if (i == 7)  check("ones_byte", 64'(out_lsb), 64'hFF);
      if (i == 11) check("ones_hold", 64'(out_lsb), 64'hFF);
    end

    // MSB-first pattern after a fresh reset
    step(1'b1, 1'b0);
    msb_pat = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) step(1'b0, msb_pat[i]);
    check("msb_first_B2", 64'(out_msb), 64'hB2);
    check("lsb_of_B2_stream", 64'(out_lsb), 64'h4D);

    // Reset mid-word discards the partial word
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("midword_reset", 64'(out_lsb), 64'h00);
    w5a = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, w5a[i]);
      if (i == 6) check("midword_hold_zero", 64'(out_lsb), 64'h00);
    end
    check("after_abort_5A", 64'(out_lsb), 64'h5A);

    // Random stream with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_marshalling.md
Name: mux_marshalling

Overview:
- Serial-to-parallel marshaller. Captures one bit per clock from a continuous serial stream and presents each completed byte on a parallel output.
- Built mux-style, not as a shift chain. A bit-position counter steers each incoming bit into a fixed slot of a staging register.
- Sits between a bit-serial source (deserializer or link front end) and byte-wide consumers.

Parameters:
- DATA_W, 8, width of the assembled word; byte_out width equals DATA_W; legal values 2..64.
- MSB_FIRST, 0, bit order. 0 = first received bit lands in bit 0 (LSB-first). 1 = first received bit lands in bit DATA_W-1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- serial_in  input  1  serial data; one bit is sampled on every rising clk edge while rst=0.
- byte_out  output  DATA_W  last fully assembled word; held stable between updates.

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (rst); nothing is asynchronous.
- State:
  - bit_cnt: $clog2(DATA_W) bits, counts 0..DATA_W-1.
  - stage: DATA_W bits, the staging register.
  - byte_out register.
- Reset (rst=1 at a rising edge): bit_cnt=0, stage=0, byte_out=0.
  - serial_in is ignored while rst=1, including X/Z values.
- Each rising edge with rst=0:
  - Slot index = bit_cnt when MSB_FIRST=0, or DATA_W-1-bit_cnt when MSB_FIRST=1.
  - stage[slot] <= serial_in; all other stage bits hold.
  - When bit_cnt != DATA_W-1: bit_cnt increments.
  - When bit_cnt == DATA_W-1: byte_out <= stage with the final slot replaced by the current serial_in, so the completing bit is included in the same edge. bit_cnt wraps to 0.
- No framing, no idle detection. The block runs continuously after reset, so every DATA_W consecutive sampled bits form one word.
- Latency: byte_out reflects the new word immediately after the edge that samples the DATA_W-th bit. First word appears DATA_W edges after rst deasserts.
- byte_out changes only on word completion or reset. It holds between completions.
- stage is not cleared on word completion. Stale bits are always overwritten before the next completion.
- Reset mid-word discards the partial word: bit_cnt=0 and byte_out=0 on the next edge.
- rst and a completion on the same edge: reset wins.
- No combinational path from serial_in to byte_out.

Optional Feature:
- Macro MUX_MARSHALLING_VALID_EN.
- Defined: adds output port byte_valid (1 bit).
  - byte_valid=1 for exactly one cycle, the cycle in which byte_out has just been updated by a completion. Otherwise 0.
  - Reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles with serial_in=X -> byte_out=0x00; bit_cnt=0 (byte_valid=0 if enabled).
- LSB-first stream, DATA_W=8, MSB_FIRST=0:
  - Drive bits 0..31 of 0xABCD1234 one per cycle, starting the edge after rst deasserts.
  - byte_out takes 0x34, 0x12, 0xCD, 0xAB after edges 8, 16, 24, 32.
  - Each value holds for 8 cycles.
- Continuous run: after the above, hold serial_in=1 for 12 cycles -> byte_out=0xFF after edge 40; holds through edge 44.
- MSB-first: MSB_FIRST=1, drive 1,0,1,1,0,0,1,0 -> byte_out=0xB2 after the 8th edge.
- Reset mid-word:
  - Feed 5 bits of 1, assert rst for one cycle -> byte_out=0x00.
  - Then feed 0x5A LSB-first -> byte_out=0x5A after 8 further edges, with no residue from the aborted word.
- With MUX_MARSHALLING_VALID_EN defined, repeat the 32-bit stream -> byte_valid pulses exactly 4 times, one cycle each, coincident with each byte_out update.
